// File: rtl/kmeans_pkg.sv
// Shared types, default widths and the saturating adder for the K-means
// nearest-centroid datapath.
package kmeans_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DIST_W = 40;
  localparam int DEF_K_MAX  = 16;
  localparam int DEF_IDX_W  = $clog2(DEF_K_MAX);

  typedef enum logic {ACC, HOLD} state_e;

  typedef logic [DEF_DIST_W-1:0] dist_t;
  typedef logic [DEF_IDX_W-1:0]  idx_t;

  // Adds two unsigned values and clamps to 2^w-1 (w <= 63); ovf flags a clamp.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w,
                                          output logic ovf);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    ovf = (sum > lim);
    return ovf ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/abs_diff.sv
// Combinational |a - b| for signed operands, widened by one bit so the
// magnitude never wraps.
module abs_diff
  import kmeans_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   mag
);

  logic            op;
  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;
  logic [DATA_W:0] diff;

  // Same add/subtract form as the upstream unit: subtract = invert b, carry-in 1.
  assign op = 1'b1;

  always_comb begin
    a_x  = {a[DATA_W-1], a};
    b_x  = {b[DATA_W-1], b} ^ {(DATA_W+1){op}};
    diff = a_x + b_x + (DATA_W+1)'(op);
    mag  = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;
  end

endmodule

// File: rtl/kmeans_nearest_centroid.sv
// Streaming L1 distance accumulator with argmin across centroids; one
// result per query point, held until the consumer takes it.
module kmeans_nearest_centroid
  import kmeans_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIST_W = DEF_DIST_W,
  parameter int K_MAX  = DEF_K_MAX,
  parameter int IDX_W  = $clog2(K_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pt_coord,
  input  logic [DATA_W-1:0] ctr_coord,
  input  logic              last_dim,
  input  logic              last_ctr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DIST_W-1:0] out_dist,
  output logic              out_ovf
);

  state_e              state_q, state_d;
  logic [DIST_W-1:0]   acc_q, acc_d;
  logic [DIST_W-1:0]   min_dist_q, min_dist_d;
  logic [IDX_W-1:0]    min_idx_q, min_idx_d;
  logic [IDX_W-1:0]    ctr_cnt_q, ctr_cnt_d;
  logic                seen_q, seen_d;
  logic                ovf_q, ovf_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic [DIST_W-1:0]   out_dist_q, out_dist_d;
  logic                out_ovf_q, out_ovf_d;

  logic [DATA_W:0]     mag;
  logic [DIST_W-1:0]   cand;
  logic                sat_ovf;
  logic                take;

  abs_diff #(.DATA_W(DATA_W)) u_abs_diff (
    .a   (pt_coord),
    .b   (ctr_coord),
    .mag (mag)
  );

  always_comb begin
    sat_ovf = 1'b0;
    cand    = DIST_W'(sat_add(64'(acc_q), 64'(mag), DIST_W, sat_ovf));
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    min_dist_d = min_dist_q;
    min_idx_d  = min_idx_q;
    ctr_cnt_d  = ctr_cnt_q;
    seen_d     = seen_q;
    ovf_d      = ovf_q;
    out_idx_d  = out_idx_q;
    out_dist_d = out_dist_q;
    out_ovf_d  = out_ovf_q;
    take       = 1'b0;
    in_ready   = (state_q == ACC);
    out_valid  = (state_q == HOLD);

    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = cand;
          ovf_d = ovf_q | sat_ovf;
          if (last_dim) begin
            take   = !seen_q || (cand < min_dist_q);
            seen_d = 1'b1;
            acc_d  = '0;
            if (take) begin
              min_dist_d = cand;
              min_idx_d  = ctr_cnt_q;
            end
            // Counter saturates at K_MAX-1; extra centroids alias onto it.
            if (ctr_cnt_q == IDX_W'(K_MAX - 1)) begin
              if (!last_ctr) ovf_d = 1'b1;
            end else begin
              ctr_cnt_d = ctr_cnt_q + IDX_W'(1);
            end
            if (last_ctr) begin
              out_idx_d  = take ? ctr_cnt_q : min_idx_q;
              out_dist_d = take ? cand : min_dist_q;
              out_ovf_d  = ovf_d;
              state_d    = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d    = ACC;
          acc_d      = '0;
          ctr_cnt_d  = '0;
          min_dist_d = '0;
          min_idx_d  = '0;
          seen_d     = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      min_dist_q <= '0;
      min_idx_q  <= '0;
      ctr_cnt_q  <= '0;
      seen_q     <= 1'b0;
      ovf_q      <= 1'b0;
      out_idx_q  <= '0;
      out_dist_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      min_dist_q <= min_dist_d;
      min_idx_q  <= min_idx_d;
      ctr_cnt_q  <= ctr_cnt_d;
      seen_q     <= seen_d;
      ovf_q      <= ovf_d;
      out_idx_q  <= out_idx_d;
      out_dist_q <= out_dist_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_idx  = out_idx_q;
  assign out_dist = out_dist_q;
  assign out_ovf  = out_ovf_q;

endmodule

// File: doc/kmeans_nearest_centroid.md
# kmeans_nearest_centroid

Streaming L1-distance and argmin stage for the K-means datapath. It sits directly downstream of the 32-bit add/subtract unit and consumes coordinate pairs (point, centroid) one dimension per beat. It accumulates |point − centroid| over all dimensions of each centroid and tracks the minimum across centroids. It emits the winning cluster index and its distance once per query point.

## Interface
- `DATA_W`, default 32: coordinate width, signed two's complement.
- `DIST_W`, default 40: accumulator and distance width, unsigned, saturating.
- `K_MAX`, default 16: maximum centroids per query; `IDX_W = $clog2(K_MAX)`.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: beat valid.
- `in_ready`, output, 1: beat accepted when `in_valid & in_ready`.
- `pt_coord`, input, DATA_W: point coordinate for the current dimension.
- `ctr_coord`, input, DATA_W: centroid coordinate for the current dimension.
- `last_dim`, input, 1: final dimension of the current centroid.
- `last_ctr`, input, 1: current centroid is the final one for this point; only meaningful with `last_dim`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: result consumed when `out_valid & out_ready`.
- `out_idx`, output, IDX_W: index of the nearest centroid.
- `out_dist`, output, DIST_W: L1 distance to that centroid.
- `out_ovf`, output, 1: saturation occurred or centroid count exceeded K_MAX during this query.

## Operation
- The block has two states, ACC and HOLD. Reset state is ACC.
- **ACC:**
  - `in_ready=1`, `out_valid=0`.
  - Each accepted beat computes `d = |pt_coord − ctr_coord|`, evaluated at DATA_W+1 bits so there is no wrap. Example: `0x7FFFFFFF` vs `0x80000000` gives `d = 2^32−1`.
  - Candidate `c = sat(acc + d)`, where `sat` clamps to `2^DIST_W−1` and sets the overflow flag.
- **Without `last_dim`:** `acc <= c`.
- **With `last_dim`:**
  - If this is the first centroid of the query, or `c < min_dist` (strict), then `min_dist <= c` and `min_idx <= ctr_cnt`.
  - Ties keep the lower index.
  - Then `acc <= 0` and `ctr_cnt <= ctr_cnt+1`.
- **Centroid count limit:** if `ctr_cnt == K_MAX−1` and the beat has `last_dim` without `last_ctr`, the counter holds at K_MAX−1 and the overflow flag is set. Later centroids are still compared but report index K_MAX−1.
- **With `last_dim & last_ctr`:** the result is registered and the state moves to HOLD.
- **HOLD:**
  - `in_ready=0`, `out_valid=1`; outputs stay stable until `out_ready`.
  - On handshake: state returns to ACC, and `acc`, `ctr_cnt`, `min_dist`, the first-centroid flag and the overflow flag all clear.
- `last_ctr` without `last_dim` is ignored.
- A single-dimension, single-centroid query is legal.

## Timing
- Throughput is one beat per cycle in ACC.
- Result latency: `out_valid` rises the cycle after the final beat is accepted.
- One-bubble turnaround: `in_ready` returns one cycle after the output handshake. There is no same-cycle accept in HOLD.
- Reset values: `in_ready=1`, `out_valid=0`, `out_idx=0`, `out_dist=0`, `out_ovf=0`; all internal registers are 0.
- Reset asserted mid-query discards the partial accumulation immediately (asynchronously). The first beat after release starts a new query.
- `out_ready` held high continuously gives a 1-cycle HOLD.
- `in_valid` low in ACC holds all state (stall tolerant).

## Structure
- Shared package `kmeans_pkg` holds:
  - `DATA_W`, `DIST_W`, `K_MAX` defaults
  - the state enum `{ACC, HOLD}`
  - the `dist_t` and `idx_t` typedefs
  - a saturating-add function
- One sub-module, `abs_diff`: combinational signed subtract producing a DATA_W+1-bit magnitude. It reuses the add/subtract-with-`op` convention (subtract = invert b, carry-in 1).

## Test plan
- **Basic 2D, 3 centroids:** point (3,4); centroids (0,0), (3,5), (10,10) → `out_idx=1`, `out_dist=1`, `out_ovf=0`; `out_valid` one cycle after the last beat.
- **Tie and negatives:** point (−2); centroids (0), (−4) → both at distance 2, so `out_idx=0`, `out_dist=2`.
- **Extreme operands:**
  - One dimension `0x7FFFFFFF` vs `0x80000000` → `out_dist=0xFFFFFFFF`.
  - 300 such dimensions with `DIST_W=40` → `out_dist=2^40−1`, `out_ovf=1`.
- **Backpressure and stalls:**
  - Hold `out_ready=0` for 5 cycles → outputs stable and `in_ready=0` throughout.
  - Random `in_valid` gaps → same result as the gapless run.
- **Count overflow:** 17 centroids at `K_MAX=16`, the last one nearest → `out_idx=15`, `out_ovf=1`.
- **Mid-query reset:** assert `rst_n=0` after 2 of 4 beats, then replay the query → result matches the golden model, with no carry-over.
